// File: rtl/muldiv_pkg.sv
// Shared constants, op encodings and state type for the iterative multiply/divide unit.
package muldiv_pkg;

   localparam int MD_WIDTH = 32;
   localparam int MD_ITER  = 32;
   localparam int CNT_W    = 6;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MULT   = 2'd1,
      DIV    = 2'd2,
      FINISH = 2'd3
   } state_t;

   // Two's-complement negate when neg is set; 0x80000000 maps to itself, which is its unsigned magnitude.
   function automatic logic [MD_WIDTH-1:0] cond_neg(input logic [MD_WIDTH-1:0] v, input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_quot,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH:0]   o_rem,
   output logic [WIDTH-1:0] o_quot
);

   logic [WIDTH:0] w_shift;
   logic [WIDTH:0] w_trial;
   logic           w_fits;

   // The shifted partial remainder needs one extra bit because it can reach 2*divisor-1.
   assign w_shift = {i_rem, i_quot[WIDTH-1]};
   assign w_trial = w_shift - {1'b0, i_divisor};
   assign w_fits  = (w_shift >= {1'b0, i_divisor});

   always_comb begin
      o_rem  = w_shift;
      o_quot = {i_quot[WIDTH-2:0], 1'b0};
      if (w_fits) begin
         o_rem  = w_trial;
         o_quot = {i_quot[WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/seq_muldiv.sv
// Iterative signed MULT (radix-2 Booth) / DIV (restoring, sign fix-up) unit driving Hi/Lo.
module seq_muldiv
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH,
   parameter int ITER  = MD_ITER
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_op;
   logic signed [WIDTH:0] r_acc;
   logic [WIDTH-1:0]    r_q;
   logic                r_qm1;
   logic [WIDTH-1:0]    r_b;
   logic                r_neg_q;
   logic                r_neg_r;
   logic                r_done;
   logic                r_dz;
   logic [WIDTH-1:0]    r_hi;
   logic [WIDTH-1:0]    r_lo;

   logic signed [WIDTH:0] w_b_ext;
   logic signed [WIDTH:0] w_sum;
   logic [WIDTH:0]      w_rem_nxt;
   logic [WIDTH-1:0]    w_quot_nxt;
   logic                w_last;

   assign busy     = (r_state != IDLE);
   assign done     = r_done;
   assign hi       = r_hi;
   assign lo       = r_lo;
   assign div_zero = r_dz;

   assign w_last  = (r_cnt == CNT_W'(ITER - 1));
   // Booth accumulator is one bit wider so that subtracting 0x80000000 cannot overflow.
   assign w_b_ext = {r_b[WIDTH-1], r_b};

   always_comb begin
      w_sum = r_acc;
      case ({r_q[0], r_qm1})
         2'b01:   w_sum = r_acc + w_b_ext;
         2'b10:   w_sum = r_acc - w_b_ext;
         default: w_sum = r_acc;
      endcase
   end

   div_step #(.WIDTH(WIDTH)) u_div_step (
      .i_rem     (r_acc[WIDTH-1:0]),
      .i_quot    (r_q),
      .i_divisor (r_b),
      .o_rem     (w_rem_nxt),
      .o_quot    (w_quot_nxt)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (start) begin
               if (op == OP_MULT)  w_state_nxt = MULT;
               else if (b == '0)   w_state_nxt = FINISH;
               else                w_state_nxt = DIV;
            end
         end
         MULT:    if (w_last) w_state_nxt = FINISH;
         DIV:     if (w_last) w_state_nxt = FINISH;
         FINISH:  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_op    <= OP_MULT;
         r_acc   <= '0;
         r_q     <= '0;
         r_qm1   <= 1'b0;
         r_b     <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_done  <= 1'b0;
         r_dz    <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_op  <= op;
                  r_cnt <= '0;
                  r_acc <= '0;
                  r_qm1 <= 1'b0;
                  r_dz  <= 1'b0;
                  if (op == OP_MULT) begin
                     r_q <= a;
                     r_b <= b;
                  end else begin
                     r_q     <= cond_neg(a, a[WIDTH-1]);
                     r_b     <= cond_neg(b, b[WIDTH-1]);
                     r_neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                     r_neg_r <= a[WIDTH-1];
                  end
               end
            end
            MULT: begin
               r_acc <= {w_sum[WIDTH], w_sum[WIDTH:1]};
               r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
               r_qm1 <= r_q[0];
               r_cnt <= r_cnt + 1'b1;
            end
            DIV: begin
               r_acc <= w_rem_nxt;
               r_q   <= w_quot_nxt;
               r_cnt <= r_cnt + 1'b1;
            end
            FINISH: begin
               r_done <= 1'b1;
               if (r_op == OP_MULT) begin
                  r_hi <= r_acc[WIDTH-1:0];
                  r_lo <= r_q;
               end else if (r_b == '0) begin
                  // A zero divisor magnitude means the divide was never run; Hi/Lo keep the old result.
                  r_dz <= 1'b1;
               end else begin
                  r_lo <= cond_neg(r_q, r_neg_q);
                  r_hi <= cond_neg(r_acc[WIDTH-1:0], r_neg_r);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_muldiv.sv
// Randomized scoreboard bench for seq_muldiv against a plain-arithmetic MULT/DIV reference.
module tb_seq_muldiv;

   logic        clk;
   logic        reset;
   logic        start;
   logic        op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_zero;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } exp_t;

   exp_t        scb[$];
   logic [31:0] m_hi;
   logic [31:0] m_lo;
   int          n_cmp;
   int          n_err;
   logic        mon_prev;

   seq_muldiv dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .hi       (hi),
      .lo       (lo),
      .div_zero (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: 64-bit signed product; truncating signed divide; zero divisor keeps Hi/Lo.
   function automatic void push_exp(input logic o, input logic [31:0] x, input logic [31:0] y);
      exp_t   e;
      longint p;
      int     sa;
      int     sd;
      if (o == 1'b0) begin
         p    = longint'($signed(x)) * longint'($signed(y));
         e.hi = p[63:32];
         e.lo = p[31:0];
         e.dz = 1'b0;
      end else if (y == 32'd0) begin
         e.hi = m_hi;
         e.lo = m_lo;
         e.dz = 1'b1;
      end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
         e.hi = 32'd0;
         e.lo = 32'h8000_0000;
         e.dz = 1'b0;
      end else begin
         sa   = $signed(x);
         sd   = $signed(y);
         e.lo = 32'(sa / sd);
         e.hi = 32'(sa % sd);
         e.dz = 1'b0;
      end
      m_hi = e.hi;
      m_lo = e.lo;
      scb.push_back(e);
   endfunction

   initial begin
      mon_prev = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (done) begin
            exp_t e;
            chk("done_single_cycle", 64'(mon_prev), 64'd0);
            if (scb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_done: got done=1 with no operation outstanding");
            end else begin
               e = scb.pop_front();
               chk("hi", 64'(hi), 64'(e.hi));
               chk("lo", 64'(lo), 64'(e.lo));
               chk("div_zero", 64'(div_zero), 64'(e.dz));
            end
         end
         mon_prev = done;
      end
   end

   task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                         input bit pre, input bit hold, input int glitch, input int exp_lat);
      int lat;
      bit seen;
      if (!pre) begin
         @(negedge clk);
         op = o; a = x; b = y; start = 1'b1;
         push_exp(o, x, y);
      end
      lat  = 0;
      seen = 0;
      while (!seen && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 1) begin
            chk("dz_clear_on_start", 64'(div_zero), 64'd0);
            if (!hold) start = 1'b0;
         end
         if (glitch != 0 && lat == glitch) begin
            start = 1'b1; op = ~o; a = $urandom; b = $urandom;
         end
         if (glitch != 0 && lat == glitch + 1) start = 1'b0;
         if (done) seen = 1;
         else chk("busy_in_flight", 64'(busy), 64'd1);
      end
      chk("latency", 64'(lat), 64'(exp_lat));
      if (seen) chk("busy_low_at_done", 64'(busy), 64'd0);
   endtask

   initial begin
      logic [31:0] x, y, corners [4];
      logic        o;
      int          k;
      n_cmp = 0; n_err = 0; m_hi = 0; m_lo = 0;
      reset = 1'b0; start = 1'b0; op = 1'b0; a = 32'd0; b = 32'd0;
      corners[0] = 32'h8000_0000; corners[1] = 32'hFFFF_FFFF;
      corners[2] = 32'h0000_0001; corners[3] = 32'h7FFF_FFFF;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      chk("rst_div_zero", 64'(div_zero), 64'd0);
      @(negedge clk) reset = 1'b1;

      run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 0, 0, 0, 34);
      run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, 34);
      run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 34);
      run_op(1'b1, 32'd5, 32'd0, 0, 0, 0, 2);
      repeat (3) @(posedge clk);
      #1;
      chk("dz_sticky", 64'(div_zero), 64'd1);
      chk("hi_hold_after_dz", 64'(hi), 64'hFFFF_FFFF);
      chk("lo_hold_after_dz", 64'(lo), 64'hFFFF_FFFD);
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 34);

      // Stray DIV request mid-MULT must be ignored.
      x = $urandom; y = $urandom;
      run_op(1'b0, x, y, 0, 0, 10, 34);

      // Start held through done: the next op is taken on the edge right after done.
      x = $urandom; y = $urandom;
      run_op(1'b0, x, y, 0, 1, 0, 34);
      x = $urandom; y = $urandom | 32'd1;
      op = 1'b1; a = x; b = y;
      push_exp(1'b1, x, y);
      run_op(1'b1, x, y, 1, 0, 0, 34);

      // Abort a DIV with reset, then rerun it.
      @(negedge clk);
      op = 1'b1; a = 32'd100; b = 32'd7; start = 1'b1;
      push_exp(1'b1, 32'd100, 32'd7);
      repeat (15) begin
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      reset = 1'b0;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_hi", 64'(hi), 64'd0);
      chk("abort_lo", 64'(lo), 64'd0);
      chk("abort_div_zero", 64'(div_zero), 64'd0);
      scb.delete();
      m_hi = 32'd0; m_lo = 32'd0;
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      chk("idle_after_abort", 64'(busy), 64'd0);
      run_op(1'b1, 32'd100, 32'd7, 0, 0, 0, 34);
      chk("retry_lo", 64'(lo), 64'd14);
      chk("retry_hi", 64'(hi), 64'd2);

      for (int i = 0; i < 40; i++) begin
         o = 1'($urandom_range(0, 1));
         k = $urandom_range(0, 7);
         x = (k == 0) ? corners[$urandom_range(0, 3)] : $urandom;
         k = $urandom_range(0, 7);
         if (k == 0)      y = 32'd0;
         else if (k == 1) y = corners[$urandom_range(0, 3)];
         else if (k == 2) y = 32'($urandom_range(1, 20));
         else             y = $urandom;
         run_op(o, x, y, 0, 0, 0, (o && y == 32'd0) ? 2 : 34);
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      k = 0;
      while (scb.size() != 0 && k < 50) begin
         @(posedge clk);
         k++;
      end
      #2;
      chk("scoreboard_drained", 64'(scb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/seq_muldiv.md
Name: seq_muldiv

Overview:
Iterative signed multiply/divide unit that feeds the Hi and Lo registers of the multi-cycle MIPS datapath. It is launched by the control unit for MULT/DIV with a start/done handshake and takes its operands from registers A and B. MULT uses radix-2 Booth; DIV uses restoring division with sign fix-up. The block also raises the divide-by-zero condition consumed by the exception path, which loads EPC.

Parameters:
WIDTH, 32, operand and result width; only 32 is supported by the datapath.
ITER, 32, iteration count per operation; must equal WIDTH.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  operation request; sampled only in IDLE.
op  in  1  0 = MULT, 1 = DIV.
a  in  WIDTH  multiplicand or dividend (register A).
b  in  WIDTH  multiplier or divisor (register B).
busy  out  1  high while an operation is in flight.
done  out  1  one-cycle pulse when hi/lo/div_zero are updated.
hi  out  WIDTH  product[63:32] or remainder.
lo  out  WIDTH  product[31:0] or quotient.
div_zero  out  1  set when DIV is requested with b==0.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, div_zero=0, internal accumulators=0.
- Reset mid-operation aborts the operation. hi/lo return to 0 and no done pulse is produced.
- States: IDLE, MULT, DIV, FINISH.
- IDLE, start=1 sampled at edge E0:
  - a and b are latched.
  - div_zero is cleared.
  - busy goes high.
  - counter is set to 0.
  - Next state: MULT if op=0; DIV if op=1 and b!=0; FINISH with a zero-divide flag if op=1 and b==0.
- MULT:
  - Booth register is {A[WIDTH], Q[WIDTH], q-1}, with A=0 and Q=a.
  - Each edge: add b, subtract b, or do nothing per {Q[0], q-1}, then arithmetic right shift by 1.
  - Runs ITER cycles (E1..E32), then goes to FINISH.
- DIV:
  - Operands are converted to magnitudes, and the quotient and remainder signs are recorded.
  - Restoring step per edge: shift {R, Q} left, trial-subtract |b|, restore if the result is negative, set the Q bit.
  - Runs ITER cycles (E1..E32), then goes to FINISH.
- FINISH (edge E33 for normal ops):
  - MULT: hi=A, lo=Q.
  - DIV: lo = quotient, negated if sign(a)!=sign(b). hi = remainder, negated if a<0. This follows MIPS truncation.
  - Zero-divide path: FINISH is reached at E1. hi and lo are unchanged, and div_zero=1.
  - At the same edge: done=1, busy=0, next state=IDLE.
- done is high for exactly one cycle: set at E33 (E1 for zero-divide), cleared at the following edge.
- div_zero stays high until the next accepted start or reset.
- hi and lo hold their last result between operations.
- start while busy=1, or in FINISH, is ignored; the in-flight operation is unaffected.
- start asserted in the same cycle done is high is accepted, because the state is IDLE by then. This allows back-to-back operations.
- Overflow case: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. The result wraps silently with no flag.
- All arithmetic is two's complement. Magnitude of 0x80000000 is handled in WIDTH+1 bits.
- Counter is 6 bits, compared against ITER-1 to leave MULT/DIV.

Decomposition:
- Shared package (muldiv_pkg):
  - op encodings OP_MULT=1'b0, OP_DIV=1'b1.
  - state enum {IDLE, MULT, DIV, FINISH}.
  - WIDTH and ITER constants.
- Sub-module div_step: combinational restoring-division step. Inputs: rem, quot, divisor. Outputs: next rem, next quot. The FSM and Booth step stay in the top module.

Test Plan:
- a=7, b=0xFFFFFFFD (-3), op=MULT, start pulse -> done exactly 34 edges after start, counting E0; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high during E1..E32.
- a=0x80000000, b=0x80000000, op=MULT -> hi=0x40000000, lo=0x00000000.
- a=0xFFFFFFF9 (-7), b=2, op=DIV -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_zero=0.
- a=5, b=0, op=DIV -> done at E1, div_zero=1, hi/lo keep prior values. The next accepted start clears div_zero.
- Start MULT, re-pulse start with op=DIV at E10 -> ignored; MULT result delivered at E33. Then start held high across done -> new op accepted immediately, done again 34 edges later.
- Start DIV 100/7, assert reset low at E15 for one cycle -> all outputs 0 immediately, no done pulse. A fresh start then gives lo=14, hi=2.
